// File: rtl/narrow_pulse_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : narrow_pulse_pkg
//  Description : Shared definitions for the narrow_pulse atom: FSM state
//                encodings and PHASE string constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package narrow_pulse_pkg;

    // Detector states; ARM blocks detection until the input is seen inactive.
    typedef enum logic [2:0] {
        ARM   = 3'd0,
        IDLE  = 3'd1,
        QUAL  = 3'd2,
        HOLD  = 3'd3,
        STUCK = 3'd4
    } np_state_t;

    // Accepted values for the PHASE parameter.
    localparam c_phase_positive = "POSITIVE";
    localparam c_phase_negative = "NEGATIVE";

endpackage : narrow_pulse_pkg
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_ff
//  Description : DEPTH-stage flop chain for bringing an asynchronous bit into
//                the clk domain. Every stage loads INIT while rst is high.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_ff #(
    parameter int   DEPTH = 2,
    parameter logic INIT  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    generate
        if (DEPTH == 1) begin : g_single
            logic r_ff;

            // Single stage: one flop straight from the input.
            always_ff @(posedge clk) begin
                if (rst) r_ff <= INIT;
                else     r_ff <= d;
            end

            assign q = r_ff;
        end else begin : g_chain
            logic [DEPTH-1:0] r_chain;

            // Shift the input through the chain; the MSB is the synchronized bit.
            always_ff @(posedge clk) begin
                if (rst) r_chain <= {DEPTH{INIT}};
                else     r_chain <= {r_chain[DEPTH-2:0], d};
            end

            assign q = r_chain[DEPTH-1];
        end
    endgenerate

endmodule : sync_ff
`default_nettype wire

// File: rtl/narrow_pulse.sv
`default_nettype none
// ============================================================================
//  Module      : narrow_pulse
//  Description : Converts a stretched, possibly asynchronous input pulse into
//                a single-cycle output pulse once it has been active for LEN
//                synchronized samples. Short pulses raise glitch, pulses that
//                reach MAX_LEN samples raise err.
//  Revision    : 1.0 - initial release
// ============================================================================
module narrow_pulse
    import narrow_pulse_pkg::*;
#(
    parameter     PHASE   = c_phase_positive,
    parameter int LEN     = 4,
    parameter int MAX_LEN = 64,
    parameter int SYNC    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic glitch,
    output logic err,
    output logic busy
);

    localparam logic c_active = (PHASE == c_phase_negative) ? 1'b0 : 1'b1;
    localparam logic c_idle   = ~c_active;
    localparam int   c_cnt_w  = $clog2(MAX_LEN + 1);
    localparam int   c_arm_w  = $clog2(SYNC + 1);

    localparam logic [c_cnt_w-1:0] c_len  = c_cnt_w'(LEN);
    localparam logic [c_cnt_w-1:0] c_max  = c_cnt_w'(MAX_LEN);
    localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);
    localparam logic [c_arm_w-1:0] c_sync = c_arm_w'(SYNC);
    localparam logic [c_arm_w-1:0] c_arm1 = c_arm_w'(1);

    logic               w_d_s;
    logic               w_act;

    np_state_t          r_state;
    np_state_t          w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [c_cnt_w-1:0] w_cnt_inc;
    // ARM ignores the first SYNC samples after reset: they are the reset-loaded
    // idle level, not the real input, and would otherwise let a still-active
    // input slip out of ARM.
    logic [c_arm_w-1:0] r_arm_cnt;
    logic [c_arm_w-1:0] w_arm_nxt;

    logic               w_q_stb;
    logic               w_glitch_stb;
    logic               w_err_stb;
    logic               r_q;
    logic               r_glitch;
    logic               r_err;

    sync_ff #(
        .DEPTH (SYNC),
        .INIT  (c_idle)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (d),
        .q   (w_d_s)
    );

    assign w_act     = (w_d_s == c_active);
    assign w_cnt_inc = r_cnt + c_one;

    // Next-state, counter and strobe decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_arm_nxt    = r_arm_cnt;
        w_q_stb      = 1'b0;
        w_glitch_stb = 1'b0;
        w_err_stb    = 1'b0;

        case (r_state)
            ARM: begin
                if (r_arm_cnt != c_sync) begin
                    w_arm_nxt = r_arm_cnt + c_arm1;
                end else if (!w_act) begin
                    w_state_nxt = IDLE;
                end
            end

            IDLE: begin
                if (w_act) begin
                    w_cnt_nxt = c_one;
                    if (LEN == 1) begin
                        w_state_nxt = HOLD;
                        w_q_stb     = 1'b1;
                    end else begin
                        w_state_nxt = QUAL;
                    end
                end
            end

            QUAL: begin
                if (w_act) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == c_len) begin
                        w_state_nxt = HOLD;
                        w_q_stb     = 1'b1;
                    end
                end else begin
                    w_state_nxt  = IDLE;
                    w_cnt_nxt    = '0;
                    w_glitch_stb = 1'b1;
                end
            end

            HOLD: begin
                if (w_act) begin
                    // Saturating: the count never passes MAX_LEN.
                    if (r_cnt != c_max) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == c_max) begin
                            w_state_nxt = STUCK;
                            w_err_stb   = 1'b1;
                        end
                    end
                end else begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            end

            STUCK: begin
                if (!w_act) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            end

            default: begin
                w_state_nxt = ARM;
                w_cnt_nxt   = '0;
                w_arm_nxt   = '0;
            end
        endcase
    end

    // State, counters and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ARM;
            r_cnt     <= '0;
            r_arm_cnt <= '0;
            r_q       <= c_idle;
            r_glitch  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_arm_cnt <= w_arm_nxt;
            r_q       <= w_q_stb ? c_active : c_idle;
            r_glitch  <= w_glitch_stb;
            r_err     <= w_err_stb;
        end
    end

    assign q      = r_q;
    assign glitch = r_glitch;
    assign err    = r_err;
    assign busy   = (r_state == QUAL) || (r_state == HOLD) || (r_state == STUCK);

endmodule : narrow_pulse
`default_nettype wire
